// File: rtl/lab3_mem_refill_mem.sv
// lab3_mem_refill_mem: line-granular (16B) memory responder for the cache2mem
// request/response interface. Serves one request at a time after a fixed
// latency. Optional macro LAB3_MEM_REFILL_MEM_RAND_DELAY_EN adds 0..3 random
// extra wait cycles per transaction, drawn from an 8-bit LFSR.

package lab3_mem_refill_mem_pkg;

   typedef struct packed {
      logic [2:0]   mtype;    // 0 read, 1 write, 2 init
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic [2:0]   mtype;
      logic [7:0]   opaque;
      logic [1:0]   test;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_resp_16B_t;

endpackage

module lab3_mem_refill_mem
   import lab3_mem_refill_mem_pkg::*;
#(
   parameter int p_num_lines = 256,
   parameter int p_latency   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  mem_req_16B_t  mem_reqstream_msg,
   input  logic          mem_reqstream_val,
   output logic          mem_reqstream_rdy,
   output mem_resp_16B_t mem_respstream_msg,
   output logic          mem_respstream_val,
   input  logic          mem_respstream_rdy
);

   localparam int c_idx_w = $clog2(p_num_lines);
   // Wide enough for p_latency up to 255 plus up to 3 random extra cycles.
   localparam int c_cnt_w = 9;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [c_cnt_w-1:0]   count_reg;
   logic [c_cnt_w-1:0]   delay_total;
   logic                 accept;
   logic                 load_resp;

   logic [127:0]         line_mem [p_num_lines];
   logic [c_idx_w-1:0]   req_idx;
   logic [c_idx_w-1:0]   idx_reg;
   logic [2:0]           type_reg;
   logic [7:0]           opaque_reg;

   // Fields seen at the RESP transition: the live request when jumping
   // straight from IDLE (zero total delay), otherwise the latched copy.
   logic [c_idx_w-1:0]   cur_idx;
   logic [2:0]           cur_type;
   logic [7:0]           cur_opaque;

   logic [127:0]         rd_data_reg;
   logic                 data_sel_reg;
   logic [2:0]           resp_type_reg;
   logic [7:0]           resp_opaque_reg;
   logic [1:0]           resp_test_reg;

   logic                 unused_bits;

   assign req_idx = mem_reqstream_msg.addr[4 +: c_idx_w];
   // Offset, length and aliased upper address bits carry no meaning here.
   assign unused_bits = ^{mem_reqstream_msg.addr, mem_reqstream_msg.len};

   // Ready depends only on state; held low while reset is asserted.
   assign mem_reqstream_rdy  = (state_reg == IDLE) && !reset;
   assign mem_respstream_val = (state_reg == RESP);
   assign accept             = mem_reqstream_val && mem_reqstream_rdy;

   assign cur_idx    = (state_reg == IDLE) ? req_idx : idx_reg;
   assign cur_type   = (state_reg == IDLE) ? mem_reqstream_msg.mtype : type_reg;
   assign cur_opaque = (state_reg == IDLE) ? mem_reqstream_msg.opaque : opaque_reg;

`ifdef LAB3_MEM_REFILL_MEM_RAND_DELAY_EN
   logic [7:0] lfsr_reg;

   // LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr_reg <= 8'hA5;
      else if (accept)
         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
   end

   assign delay_total = c_cnt_w'(p_latency) + {{(c_cnt_w-2){1'b0}}, lfsr_reg[1:0]};
`else
   assign delay_total = c_cnt_w'(p_latency);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; load_resp marks the edge that enters RESP.
   always_comb begin
      state_next = state_reg;
      load_resp  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (delay_total == '0) begin
                  state_next = RESP;
                  load_resp  = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (count_reg == '0) begin
               state_next = RESP;
               load_resp  = 1'b1;
            end
         end
         RESP: begin
            if (mem_respstream_rdy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Wait counter: loads total delay minus one on accept, counts down in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_reg <= '0;
      else if (accept && delay_total != '0)
         count_reg <= delay_total - c_cnt_w'(1);
      else if (state_reg == WAIT && count_reg != '0)
         count_reg <= count_reg - c_cnt_w'(1);
   end

   // Latch the request fields needed later for the response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg    <= '0;
         type_reg   <= '0;
         opaque_reg <= '0;
      end else if (accept) begin
         idx_reg    <= req_idx;
         type_reg   <= mem_reqstream_msg.mtype;
         opaque_reg <= mem_reqstream_msg.opaque;
      end
   end

   // Response header registers, captured when entering RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_type_reg   <= '0;
         resp_opaque_reg <= '0;
         resp_test_reg   <= '0;
         data_sel_reg    <= 1'b0;
      end else if (load_resp) begin
         resp_type_reg   <= cur_type;
         resp_opaque_reg <= cur_opaque;
         resp_test_reg   <= (cur_type > 3'd2) ? 2'b01 : 2'b00;
         data_sel_reg    <= (cur_type == 3'd0);
      end
   end

   // Line storage: write at accept, registered read when entering RESP.
   always_ff @(posedge clk) begin
      if (accept && (mem_reqstream_msg.mtype == 3'd1 || mem_reqstream_msg.mtype == 3'd2))
         line_mem[req_idx] <= mem_reqstream_msg.data;
      if (load_resp && cur_type == 3'd0)
         rd_data_reg <= line_mem[cur_idx];
   end

   assign mem_respstream_msg.mtype  = resp_type_reg;
   assign mem_respstream_msg.opaque = resp_opaque_reg;
   assign mem_respstream_msg.test   = resp_test_reg;
   assign mem_respstream_msg.len    = 4'd0;
   assign mem_respstream_msg.data   = data_sel_reg ? rd_data_reg : 128'd0;

endmodule
